// File: rtl/mmio_led_timer.sv
// Memory-mapped LED/RGB PWM duty register plus free-running microsecond and millisecond timers.
// Occupies 12 bytes at BASE_ADDR; load data and the hit flag are registered.
module mmio_led_timer #(
    parameter int unsigned CLK_FREQ_HZ = 12000000,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFFFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  funct3,
    input  logic        dmem_wren,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_data_in,
    output logic [31:0] dmem_data_out,
    output logic        hit,
    output logic        led,
    output logic        red,
    output logic        green,
    output logic        blue
);

    localparam logic [31:0] PrescaleMax = 32'(CLK_FREQ_HZ / 1000000 - 1);

    logic [31:0]      offset;
    logic             in_range;
    logic [1:0]       word_sel;
    logic [1:0]       lane;
    logic [3:0]       byte_en;
    logic [31:0]      wr_data;
    logic [31:0]      duty_q, duty_d;
    logic [31:0]      rd_word, rd_shift, rd_ext;
    logic [31:0]      dout_q;
    logic             hit_q;
    logic [7:0]       pwm_cnt_q;
    logic [3:0][7:0]  shadow_q;
    logic [3:0]       pwm_d, pwm_q;
    logic [31:0]      presc_q;
    logic [9:0]       us_sub_q;
    logic [31:0]      us_q, ms_q;
    logic             presc_tc, sub_tc;

    // Subtract first so the range test cannot overflow at the top of the address space.
    assign offset   = dmem_address - BASE_ADDR;
    assign in_range = (dmem_address >= BASE_ADDR) && (offset < 32'd12);
    assign word_sel = offset[3:2];
    assign lane     = dmem_address[1:0];
    assign wr_data  = dmem_data_in << {lane, 3'b000};

    always_comb begin
        byte_en = 4'b0000;
        case (funct3[1:0])
            2'b00:   byte_en = 4'b0001 << lane;
            2'b01:   byte_en = lane[0] ? 4'b0000 : (4'b0011 << lane);
            2'b10:   byte_en = (lane == 2'b00) ? 4'b1111 : 4'b0000;
            default: byte_en = 4'b0000;
        endcase
        if (!(dmem_wren && in_range && (word_sel == 2'd2))) begin
            byte_en = 4'b0000;
        end
    end

    always_comb begin
        duty_d = duty_q;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                duty_d[8*i +: 8] = wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word = 32'd0;
        case (word_sel)
            2'd0:    rd_word = us_q;
            2'd1:    rd_word = ms_q;
            2'd2:    rd_word = duty_q;
            default: rd_word = 32'd0;
        endcase
    end

    assign rd_shift = rd_word >> {lane, 3'b000};

    always_comb begin
        rd_ext = 32'd0;
        case (funct3)
            3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  rd_ext = rd_shift;
            3'b100:  rd_ext = {24'd0, rd_shift[7:0]};
            3'b101:  rd_ext = {16'd0, rd_shift[15:0]};
            default: rd_ext = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            duty_q <= 32'd0;
            dout_q <= 32'd0;
            hit_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            dout_q <= in_range ? rd_ext : 32'd0;
            hit_q  <= in_range;
        end
    end

    // Shadows sample the old duty on the wrap edge so a period is never cut short.
    always_comb begin
        pwm_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            pwm_d[i] = (shadow_q[i] == 8'hFF) || (pwm_cnt_q < shadow_q[i]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_cnt_q <= 8'd0;
            shadow_q  <= '0;
            pwm_q     <= 4'b0000;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
            if (pwm_cnt_q == 8'hFF) begin
                shadow_q <= duty_q;
            end
            pwm_q <= pwm_d;
        end
    end

    assign presc_tc = (presc_q == PrescaleMax);
    assign sub_tc   = (us_sub_q == 10'd999);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q  <= 32'd0;
            us_sub_q <= 10'd0;
            us_q     <= 32'd0;
            ms_q     <= 32'd0;
        end else if (presc_tc) begin
            presc_q  <= 32'd0;
            us_q     <= us_q + 32'd1;
            us_sub_q <= sub_tc ? 10'd0 : us_sub_q + 10'd1;
            if (sub_tc) begin
                ms_q <= ms_q + 32'd1;
            end
        end else begin
            presc_q <= presc_q + 32'd1;
        end
    end

    assign dmem_data_out = dout_q;
    assign hit           = hit_q;
    assign led           = pwm_q[3];
    assign red           = pwm_q[2];
    assign green         = pwm_q[1];
    assign blue          = pwm_q[0];

endmodule

// File: tb/tb_mmio_led_timer.sv
// Directed bench for mmio_led_timer: bus reads/writes, PWM duty behaviour, timers and reset.
module tb_mmio_led_timer;

    localparam logic [31:0] Base = 32'hFFFFFFF4;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  funct3;
    logic        dmem_wren;
    logic [31:0] dmem_address;
    logic [31:0] dmem_data_in;
    logic [31:0] dmem_data_out;
    logic        hit;
    logic        led, red, green, blue;

    int n_checks = 0;
    int n_pass   = 0;

    mmio_led_timer #(
        .CLK_FREQ_HZ(12000000),
        .BASE_ADDR  (Base)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .funct3       (funct3),
        .dmem_wren    (dmem_wren),
        .dmem_address (dmem_address),
        .dmem_data_in (dmem_data_in),
        .dmem_data_out(dmem_data_out),
        .hit          (hit),
        .led          (led),
        .red          (red),
        .green        (green),
        .blue         (blue)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Called at a falling edge: drive for one rising edge, then park the bus out of range.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
        dmem_wren    = 1'b1;
        dmem_address = addr;
        dmem_data_in = data;
        funct3       = f3;
        @(negedge clk);
        dmem_wren    = 1'b0;
        dmem_address = 32'h0;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] f3,
                      output logic [31:0] data, output logic h);
        dmem_wren    = 1'b0;
        dmem_address = addr;
        funct3       = f3;
        @(negedge clk);
        data         = dmem_data_out;
        h            = hit;
        dmem_address = 32'h0;
    endtask

    initial begin
        logic [31:0] d;
        logic        h;
        int          c_led, c_red, c_green, c_blue, run;
        logic        prev, found;

        reset = 1'b0; funct3 = 3'b010; dmem_wren = 1'b0;
        dmem_address = 32'h0; dmem_data_in = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_pwm", {28'd0, led, red, green, blue}, 32'd0);
        check("rst_hit", {31'd0, hit}, 32'd0);
        check("rst_dout", dmem_data_out, 32'd0);
        reset = 1'b1;
        rd(Base, 3'b010, d, h);
        check("us_after_release", d, 32'd0);
        check("us_hit", {31'd0, h}, 32'd1);

        // LED and red full on
        wr(Base + 8, 32'hFFFF0000, 3'b010);
        rd(Base + 8, 3'b010, d, h);
        check("lw_duty", d, 32'hFFFF0000);
        check("lw_duty_hit", {31'd0, h}, 32'd1);
        repeat (600) @(negedge clk);
        c_led = 0; c_red = 0; c_green = 0; c_blue = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c_led += int'(led); c_red += int'(red);
            c_green += int'(green); c_blue += int'(blue);
        end
        check("led_full", 32'(c_led), 32'd256);
        check("red_full", 32'(c_red), 32'd256);
        check("green_off", 32'(c_green), 32'd0);
        check("blue_off", 32'(c_blue), 32'd0);

        // Asynchronous reset mid-period
        dmem_address = Base + 8;
        funct3 = 3'b010;
        @(negedge clk);
        check("hit_before_rst", {31'd0, hit}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_pwm", {28'd0, led, red, green, blue}, 32'd0);
        check("async_rst_hit", {31'd0, hit}, 32'd0);
        check("async_rst_dout", dmem_data_out, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        dmem_address = 32'h0;
        rd(Base + 8, 3'b010, d, h);
        check("duty_cleared", d, 32'd0);

        // Blue half duty
        wr(Base + 8, 32'h00000080, 3'b010);
        repeat (600) @(negedge clk);
        c_blue = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            c_blue += int'(blue);
        end
        check("blue_128", 32'(c_blue), 32'd128);

        // Align to a blue rising edge, then byte-write a new duty mid pulse
        prev = blue; found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (blue && !prev) found = 1'b1;
            prev = blue;
        end
        check("blue_rise_seen", {31'd0, found}, 32'd1);
        run = 1;
        dmem_wren = 1'b1; dmem_address = Base + 8; dmem_data_in = 32'h40; funct3 = 3'b000;
        @(negedge clk);
        run += int'(blue);
        dmem_wren = 1'b0; dmem_address = 32'h0;
        for (int i = 0; i < 300 && blue; i++) begin
            @(negedge clk);
            run += int'(blue);
        end
        check("blue_pulse_not_truncated", 32'(run), 32'd128);
        prev = blue; found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (blue && !prev) found = 1'b1;
            prev = blue;
        end
        run = int'(found);
        for (int i = 0; i < 300 && blue; i++) begin
            @(negedge clk);
            run += int'(blue);
        end
        check("blue_pulse_64", 32'(run), 32'd64);

        // Byte lanes and load extension
        wr(Base + 10, 32'h0000ABCD, 3'b001);
        rd(Base + 8, 3'b010, d, h);
        check("sh_upper_half", d, 32'hABCD0040);
        rd(Base + 11, 3'b000, d, h);
        check("lb_sign", d, 32'hFFFFFFAB);
        rd(Base + 11, 3'b100, d, h);
        check("lbu_zero", d, 32'h000000AB);
        rd(Base + 10, 3'b001, d, h);
        check("lh_sign", d, 32'hFFFFABCD);
        rd(Base + 10, 3'b101, d, h);
        check("lhu_zero", d, 32'h0000ABCD);
        rd(Base + 8, 3'b000, d, h);
        check("lb_positive", d, 32'h00000040);
        rd(Base + 9, 3'b010, d, h);
        check("lw_misaligned_shift", d, 32'h00ABCD00);
        rd(Base + 8, 3'b011, d, h);
        check("bad_funct3_read", d, 32'h0);
        wr(Base + 9, 32'h12345678, 3'b010);
        wr(Base + 9, 32'h00001234, 3'b001);
        wr(Base + 8, 32'h55555555, 3'b011);
        rd(Base + 8, 3'b010, d, h);
        check("ignored_writes", d, 32'hABCD0040);

        // Out of range
        rd(32'h00001000, 3'b010, d, h);
        check("oor_dout", d, 32'h0);
        check("oor_hit", {31'd0, h}, 32'd0);
        wr(32'h00001000, 32'h11111111, 3'b010);
        rd(Base + 8, 3'b010, d, h);
        check("oor_write_ignored", d, 32'hABCD0040);

        // Timers: 24012 edges after release -> 2001 us, 2 ms
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (24010) @(negedge clk);
        wr(Base + 0, 32'h0, 3'b010);
        wr(Base + 4, 32'h0, 3'b010);
        rd(Base + 0, 3'b010, d, h);
        check("us_time", d, 32'd2001);
        rd(Base + 4, 3'b010, d, h);
        check("ms_time", d, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_led_timer.md
# mmio_led_timer

Memory-mapped peripheral that responds to the processor's data-memory bus (funct3 / dmem_wren / dmem_address / dmem_data_in / dmem_data_out) in the top 12 bytes of the address space. It provides:
- one LED/RGB duty register that drives PWM outputs for the board LED and RGB channels;
- two read-only free-running timers (microseconds and milliseconds).

It sits beside `memory` in `top`. Its registered hit flag selects between the two read-data sources.

## Interface
- CLK_FREQ_HZ, 12000000: clock frequency; must be an integer multiple of 1 MHz.
- BASE_ADDR, 32'hFFFFFFF4: address of the lowest register; the block occupies BASE_ADDR..BASE_ADDR+11.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- funct3  in  3  access size/sign, RV32I load/store encoding.
- dmem_wren  in  1  write strobe, sampled on the rising edge.
- dmem_address  in  32  byte address.
- dmem_data_in  in  32  store data, right-aligned (LSBs), RV32I style.
- dmem_data_out  out  32  registered load data, already lane-shifted and sign/zero-extended.
- hit  out  1  registered; 1 when the previous cycle's address fell in this block's range.
- led, red, green, blue  out  1  active-high PWM outputs (top inverts them for the pads).

## Operation
Register map (word offsets from BASE_ADDR):
- +0 US_TIME: microsecond counter, 32-bit, read-only.
- +4 MS_TIME: millisecond counter, 32-bit, read-only.
- +8 LED_DUTY: read/write duty register.
  - byte3 = led duty, byte2 = red, byte1 = green, byte0 = blue.
  - Example: 32'hFFFF0000 means LED and red full on.

Writes:
- Occur on the rising edge with dmem_wren=1 and the address in range.
- funct3[1:0] sets the size: 00 = byte, 01 = half, 10 = word.
- Byte lane = addr[1:0]. Data is taken from dmem_data_in LSBs and shifted to the lane.
- Ignored cases:
  - misaligned half (addr[0]=1) or word (addr[1:0]≠0);
  - any write to US_TIME or MS_TIME;
  - funct3[1:0]=11.

Reads:
- Every cycle, the addressed word is captured, shifted right by addr[1:0]*8, then extended per funct3:
  - 000 LB: sign-extend byte.
  - 001 LH: sign-extend half.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Others: zero.
- Out of range: dmem_data_out=0, hit=0.
- Misaligned reads return the shifted value; alignment is not checked on reads.

PWM:
- pwm_cnt is an 8-bit counter, incrementing every clock and wrapping 255→0. Period is 256 clocks.
- Each channel has a shadow duty register. All four shadows load from LED_DUTY on the edge where pwm_cnt wraps 255→0, so a new duty applies from the next period start and no glitches occur mid-period.
- Channel output = 1 when shadow==8'hFF, else (pwm_cnt < shadow).
  - duty 0 = constant 0.
  - duty 255 = constant 1.
- Outputs are registered.

Timers:
- A prescaler counts 0..CLK_FREQ_HZ/1e6−1. US_TIME increments on the prescaler's terminal count.
- A sub-counter counts 0..999 microseconds. MS_TIME increments when both the sub-counter and the prescaler are terminal.
- Both counters wrap at 2^32 silently.

## Timing
- Reset (reset=0, asynchronous) clears:
  - LED_DUTY, shadows, pwm_cnt, prescaler, us sub-counter, US_TIME, MS_TIME to 0;
  - dmem_data_out=0, hit=0;
  - led, red, green, blue = 0.
- Reset asserted mid-period: outputs drop to 0 immediately and asynchronously.
- Reset deassertion: counters start on the first rising edge after release.
- Write latency: LED_DUTY is updated at the write edge. Outputs reflect it after the next 255→0 wrap, worst case 256 cycles + 1 register stage.
- Read latency: 1 cycle. Address presented in cycle N gives dmem_data_out and hit valid after edge N+1, held until the next edge.
- Read and write to LED_DUTY in the same cycle: the read returns the old value.
- Timer read in the cycle the counter increments: returns the pre-increment value.
- A write landing exactly on the wrap edge: the shadow loads the old LED_DUTY, and the new value takes effect one period later.

## Test plan
- Reset: hold reset=0 mid-run, then release → all outputs 0, and US_TIME reads 0 at the first read after release.
- SW 32'hFFFF0000 to BASE+8, run 600 cycles → led and red constant 1 after the first wrap; green and blue constant 0. LW BASE+8 returns 32'hFFFF0000 with hit=1 one cycle later.
- SW 32'h00000080 → blue high for exactly 128 of every 256 cycles. Then SB 8'h40 to BASE+8 → blue duty changes to 64/256 only at the next period boundary, with no truncated high pulse.
- Byte-lane and extension checks:
  - SH 16'hABCD at BASE+10 → LED_DUTY = 32'hABCD00xx (lower half unchanged).
  - LB BASE+11 → 32'hFFFFFFAB.
  - LBU BASE+11 → 32'h000000AB.
  - Misaligned SW at BASE+9 → LED_DUTY unchanged.
- Timers with CLK_FREQ_HZ=12000000, run 24,012,000 cycles from reset → US_TIME = 2,001,000 and MS_TIME = 2001. SW to BASE+0 → no change.
- Out-of-range LW at 32'h00001000 → hit=0, dmem_data_out=0. A wren at that address → no register changes.
